// File: rtl/tta_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tta_mem_arbiter
// Purpose  : Shares one in-order memory port between an instruction-fetch (I)
//            requester and a data (D) requester. Requests, acks and ready
//            strobes pass through combinationally, so the arbiter adds no
//            cycles of latency. A tag FIFO remembers which requester owns each
//            outstanding read so read data can be routed back.
// Ports    : clock_i / reset_i          clock, synchronous active-high reset
//            i_read_i, i_addr_i         instruction read request
//            i_rack_o, i_ready_o,
//            i_data_o                   instruction accept / data valid / data
//            d_read_i, d_write_i,
//            d_addr_i, d_bes_ni,
//            d_data_i                   data read/write request
//            d_rack_o, d_wack_o,
//            d_ready_o, d_data_o        data accepts / data valid / data
//            m_*                        shared memory port
//            err_o                      sticky protocol error
// Options  : ARB_ROUND_ROBIN_EN  defined   -> round-robin on contention
//                                undefined -> data side always wins
// Revision : 1.0  initial release
// ============================================================================
module tta_mem_arbiter #(
    parameter int ADDRESS  = 28,
    parameter int DATA     = 32,
    parameter int TAGDEPTH = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    // instruction side
    input  logic                  i_read_i,
    output logic                  i_rack_o,
    output logic                  i_ready_o,
    input  logic [ADDRESS-1:0]    i_addr_i,
    output logic [DATA-1:0]       i_data_o,
    // data side
    input  logic                  d_read_i,
    input  logic                  d_write_i,
    output logic                  d_rack_o,
    output logic                  d_wack_o,
    output logic                  d_ready_o,
    input  logic [ADDRESS-1:0]    d_addr_i,
    input  logic [DATA/8-1:0]     d_bes_ni,
    input  logic [DATA-1:0]       d_data_i,
    output logic [DATA-1:0]       d_data_o,
    // shared memory port
    output logic                  m_read_o,
    output logic                  m_write_o,
    input  logic                  m_rack_i,
    input  logic                  m_wack_i,
    input  logic                  m_ready_i,
    input  logic                  m_busy_i,
    output logic [ADDRESS-1:0]    m_addr_o,
    output logic [DATA/8-1:0]     m_bes_no,
    output logic [DATA-1:0]       m_data_o,
    input  logic [DATA-1:0]       m_data_i,
    // status
    output logic                  err_o
);

    localparam int PTR_W = (TAGDEPTH > 1) ? $clog2(TAGDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(TAGDEPTH);
    localparam logic [PTR_W-1:0] C_LAST_PTR   = PTR_W'(TAGDEPTH - 1);
    localparam logic             C_TAG_I      = 1'b0;
    localparam logic             C_TAG_D      = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               tag_mem_q [TAGDEPTH];
    logic               tag_mem_d [TAGDEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;

    logic               w_pend_d;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic               w_pop;
    logic               w_read_room;
    logic               w_elig_i;
    logic               w_elig_d;
    logic               w_prefer_i;
    logic               w_grant_i;
    logic               w_grant_d;
    logic               w_accept;
    logic               w_push;
    logic               w_head_tag;

    // ------------------------------------------------------------------------
    // Contention policy
    // ------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    // Remembers whether the last accepted request belonged to D; it starts as
    // D so the first contended grant goes to I.
    logic last_d_q, last_d_d;

    assign w_prefer_i = last_d_q;

    always_comb begin
        last_d_d = last_d_q;
        if (w_accept) begin
            last_d_d = w_grant_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            last_d_q <= 1'b1;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign w_prefer_i = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Tag FIFO status
    // ------------------------------------------------------------------------
    assign w_fifo_empty = (count_q == '0);
    assign w_fifo_full  = (count_q == C_FULL_COUNT);
    assign w_head_tag   = tag_mem_q[rd_ptr_q];
    // Ready with nothing outstanding is a protocol error and is dropped.
    assign w_pop        = m_ready_i & ~w_fifo_empty & ~reset_i;
    // A full FIFO still takes a new read if a tag leaves in the same cycle.
    assign w_read_room  = ~w_fifo_full | w_pop;

    assign w_pend_d = d_read_i | d_write_i;

    // A read that cannot be tagged is not eligible, so a blocked read never
    // takes the grant away from a write that could issue.
    assign w_elig_i = i_read_i & w_read_room;
    assign w_elig_d = d_write_i | (d_read_i & w_read_room);

    // ------------------------------------------------------------------------
    // Grant FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        m_read_o  = 1'b0;
        m_write_o = 1'b0;
        i_rack_o  = 1'b0;
        d_rack_o  = 1'b0;
        d_wack_o  = 1'b0;
        w_accept  = 1'b0;
        state_d   = IDLE;

        case (state_q)
            HOLD_I:  w_grant_i = 1'b1;
            HOLD_D:  w_grant_d = 1'b1;
            default: begin
                if (w_elig_i && w_elig_d) begin
                    w_grant_i = w_prefer_i;
                    w_grant_d = ~w_prefer_i;
                end else begin
                    w_grant_i = w_elig_i;
                    w_grant_d = w_elig_d;
                end
            end
        endcase

        // Strobes are withheld while the port is busy or in reset; the grant
        // itself is unaffected so the FSM holds it.
        if (!reset_i && !m_busy_i) begin
            if (w_grant_i) begin
                m_read_o = i_read_i & w_read_room;
            end else if (w_grant_d) begin
                // Write wins when D raises both strobes.
                m_write_o = d_write_i;
                m_read_o  = d_read_i & ~d_write_i & w_read_room;
            end
        end

        i_rack_o = w_grant_i & m_read_o & m_rack_i;
        d_rack_o = w_grant_d & m_read_o & m_rack_i;
        d_wack_o = w_grant_d & m_write_o & m_wack_i;
        w_accept = i_rack_o | d_rack_o | d_wack_o;

        if (w_grant_i && i_read_i && !w_accept) begin
            state_d = HOLD_I;
        end else if (w_grant_d && w_pend_d && !w_accept) begin
            state_d = HOLD_D;
        end
    end

    // Address, data and byte enables follow the grant combinationally.
    assign m_addr_o = w_grant_d ? d_addr_i : i_addr_i;
    assign m_bes_no = w_grant_d ? d_bes_ni : '0;
    assign m_data_o = d_data_i;

    // Read data goes to both requesters; only the ready strobe is routed.
    assign i_data_o  = m_data_i;
    assign d_data_o  = m_data_i;
    assign i_ready_o = w_pop & (w_head_tag == C_TAG_I);
    assign d_ready_o = w_pop & (w_head_tag == C_TAG_D);

    assign w_push = i_rack_o | d_rack_o;
    assign err_o  = err_q;

    // ------------------------------------------------------------------------
    // Tag FIFO and error flag next state
    // ------------------------------------------------------------------------
    always_comb begin
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q;

        if (w_push) begin
            tag_mem_d[wr_ptr_q] = d_rack_o ? C_TAG_D : C_TAG_I;
            wr_ptr_d = (wr_ptr_q == C_LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == C_LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CNT_W'(1);
        end

        if ((m_ready_i && w_fifo_empty) || (d_read_i && d_write_i)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < TAGDEPTH; i++) begin
                tag_mem_q[i] <= 1'b0;
            end
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            tag_mem_q <= tag_mem_d;
        end
    end

endmodule
`default_nettype wire
